// File: rtl/slice_collector.sv
// slice_collector
//
// Receiving end of the 25-bit Keccak slice stream. Captures one frame of SLICES
// slices, one per accepted strobe, into a SLICES x WIDTH buffer. Completion raises
// ready, advances the round number that feeds the upstream stage, and pulses
// lastRound when the round number wraps. The buffer has a registered random-access
// read port.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active low
//   start      begin collecting a new frame (ignored while collecting)
//   in         slice data from upstream
//   inValid    in holds a valid slice this cycle
//   rdAddr     slice index to read
//   rdData     registered read data, mem[rdAddr], one cycle latency
//   ready      frame complete, all SLICES slices stored
//   busy       collecting
//   cycleNum   current round number, 0..ROUNDS-1
//   lastRound  one-cycle pulse when cycleNum wraps from ROUNDS-1 to 0
//   overrun    sticky: a slice arrived while not collecting; cleared by start

module slice_collector #(
  parameter int unsigned SLICES = 64,
  parameter int unsigned ROUNDS = 24,
  parameter int unsigned WIDTH  = 25,
  localparam int unsigned IdxW  = $clog2(SLICES),
  localparam int unsigned RndW  = $clog2(ROUNDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic             inValid,
  input  logic [IdxW-1:0]  rdAddr,
  output logic [WIDTH-1:0] rdData,
  output logic             ready,
  output logic             busy,
  output logic [RndW-1:0]  cycleNum,
  output logic             lastRound,
  output logic             overrun
);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  count_q, count_d;
  logic [RndW-1:0]  cycle_q, cycle_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  // Buffer is deliberately not reset; contents are undefined until written.
  logic [WIDTH-1:0] mem_q [SLICES];

  logic collecting;
  logic accept;
  logic frame_end;
  logic wr_en;

  assign collecting = (state_q == StCollect);
  assign accept     = collecting && inValid;
  assign frame_end  = accept && (count_q == IdxW'(SLICES - 1));
  // Writes are suppressed during reset so an abandoned frame cannot be extended.
  assign wr_en      = rst && accept;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      cycle_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      cycle_q   <= cycle_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      ovr_q     <= ovr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Slice buffer write. Non-blocking update gives read-before-write on a
  // same-address collision with the read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[count_q] <= in;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StCollect;
        end
      end
      StCollect: begin
        // start is ignored here; only the final slice ends the frame.
        if (frame_end) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values (all outputs are registered)
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d   = count_q;
    cycle_d   = cycle_q;
    last_d    = 1'b0;
    ovr_d     = ovr_q;
    rd_data_d = mem_q[rdAddr];

    if (collecting) begin
      if (accept) begin
        count_d = frame_end ? '0 : count_q + IdxW'(1);
      end
    end else if (start) begin
      // start wins over a simultaneous stray slice: no overrun, slice dropped.
      count_d = '0;
      ovr_d   = 1'b0;
    end else if (inValid) begin
      ovr_d = 1'b1;
    end

    if (frame_end) begin
      if (cycle_q == RndW'(ROUNDS - 1)) begin
        cycle_d = '0;
        last_d  = 1'b1;
      end else begin
        cycle_d = cycle_q + RndW'(1);
      end
    end

    busy_d  = (state_d == StCollect);
    ready_d = (state_d == StDone);
  end

  assign rdData    = rd_data_q;
  assign ready     = ready_q;
  assign busy      = busy_q;
  assign cycleNum  = cycle_q;
  assign lastRound = last_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_slice_collector.sv
module tb_slice_collector;

  localparam int NS = 64;
  localparam int NR = 24;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [24:0] din;
  logic [5:0]  rd_addr;
  logic [24:0] rd_data;
  logic        ready;
  logic        busy;
  logic [4:0]  cycle_num;
  logic        last_round;
  logic        overrun;

  int total;
  int bad;

  slice_collector dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in       (din),
    .inValid  (in_valid),
    .rdAddr   (rd_addr),
    .rdData   (rd_data),
    .ready    (ready),
    .busy     (busy),
    .cycleNum (cycle_num),
    .lastRound(last_round),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: frame phase, slices received so far, round number.
  typedef enum {MIdle, MCollect, MDone} mphase_e;
  mphase_e     m_phase;
  int          m_cnt;
  int          m_round;
  bit          m_last;
  bit          m_ovr;
  logic [24:0] m_mem [NS];
  bit          m_known [NS];
  logic [24:0] m_rd;
  bit          m_rd_known;

  function automatic logic [8:0] exp_status();
    return {m_phase == MCollect, m_phase == MDone, 5'(m_round), m_last, m_ovr};
  endfunction

  // Apply inputs for one clock, advance the model, wait until just after the edge.
  task automatic drive(input bit r, input bit st, input bit v, input logic [24:0] d,
                       input logic [5:0] a);
    rst = r; start = st; in_valid = v; din = d; rd_addr = a;
    if (!r) begin
      m_phase = MIdle; m_cnt = 0; m_round = 0; m_last = 0; m_ovr = 0;
      m_rd = '0; m_rd_known = 1;
    end else begin
      m_rd = m_mem[a];
      m_rd_known = m_known[a];
      m_last = 0;
      if (m_phase == MCollect) begin
        if (v) begin
          m_mem[m_cnt] = d;
          m_known[m_cnt] = 1;
          m_cnt++;
          if (m_cnt == NS) begin
            m_cnt = 0;
            m_phase = MDone;
            m_round++;
            if (m_round == NR) begin
              m_round = 0;
              m_last = 1;
            end
          end
        end
      end else if (st) begin
        m_phase = MCollect; m_cnt = 0; m_ovr = 0;
      end else if (v) begin
        m_ovr = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] raddr();
    return 6'($urandom_range(0, NS - 1));
  endfunction

  // Start plus a full frame of random data with random gaps; no checking here.
  task automatic run_frame();
    int got;
    drive(1, 1, 0, '0, raddr());
    got = 0;
    for (int c = 0; c < 1000 && got < NS; c++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      drive(1, 0, v, 25'($urandom), raddr());
      if (v) got++;
    end
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 25'h1FFFFFF, 6'd3);
    drive(0, 0, 1, 25'h0AAAAAA, 6'd4);
    total++;
    if ({busy, ready, cycle_num, last_round, overrun} !== 9'b0) begin
      bad++;
      $display("FAIL reset_status got %b want %b", {busy, ready, cycle_num, last_round, overrun},
               9'b0);
    end
    total++;
    if (rd_data !== 25'd0) begin
      bad++;
      $display("FAIL reset_rddata got %h want 0", rd_data);
    end
  endtask

  task automatic test_full_round();
    drive(1, 1, 0, '0, raddr());
    for (int i = 0; i < NS; i++) begin
      drive(1, 0, 1, 25'(i * 32'h10001), raddr());
      total++;
      if ({busy, ready, cycle_num, last_round, overrun} !== exp_status()) begin
        bad++;
        $display("FAIL full_status slice %0d got %b want %b", i,
                 {busy, ready, cycle_num, last_round, overrun}, exp_status());
      end
    end
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || cycle_num !== 5'd1) begin
      bad++;
      $display("FAIL full_done got ready=%b busy=%b cyc=%0d want 1 0 1", ready, busy, cycle_num);
    end
    for (int a = 0; a < NS; a++) begin
      drive(1, 0, 0, '0, 6'(a));
      total++;
      if (rd_data !== 25'(a * 32'h10001)) begin
        bad++;
        $display("FAIL full_read addr %0d got %h want %h", a, rd_data, 25'(a * 32'h10001));
      end
    end
  endtask

  task automatic test_gapped();
    drive(1, 1, 0, '0, raddr());
    for (int k = 0; k < 2 * NS; k++) begin
      drive(1, 0, (k % 2) == 0, 25'($urandom), raddr());
      total++;
      if ({busy, ready, cycle_num, last_round, overrun} !== exp_status()) begin
        bad++;
        $display("FAIL gap_status step %0d got %b want %b", k,
                 {busy, ready, cycle_num, last_round, overrun}, exp_status());
      end
      if (m_rd_known) begin
        total++;
        if (rd_data !== m_rd) begin
          bad++;
          $display("FAIL gap_rd step %0d got %h want %h", k, rd_data, m_rd);
        end
      end
    end
    for (int a = 0; a < NS; a++) begin
      drive(1, 0, 0, '0, 6'(a));
      total++;
      if (rd_data !== m_mem[a]) begin
        bad++;
        $display("FAIL gap_read addr %0d got %h want %h", a, rd_data, m_mem[a]);
      end
    end
  endtask

  task automatic test_rounds();
    int pulses;
    bit wrapped;
    pulses = 0;
    wrapped = 0;
    for (int f = 0; f < NR + 2 && !wrapped; f++) begin
      drive(1, 1, 0, '0, raddr());
      for (int c = 0; c < 1000 && m_phase != MDone; c++) begin
        drive(1, 0, $urandom_range(0, 3) != 0, 25'($urandom), raddr());
        if (last_round === 1'b1) pulses++;
        total++;
        if ({busy, ready, cycle_num, last_round, overrun} !== exp_status()) begin
          bad++;
          $display("FAIL rounds_status frame %0d got %b want %b", f,
                   {busy, ready, cycle_num, last_round, overrun}, exp_status());
        end
      end
      if (m_round == 0) wrapped = 1;
    end
    drive(1, 0, 0, '0, raddr());
    if (last_round === 1'b1) pulses++;
    total++;
    if (last_round !== 1'b0 || cycle_num !== 5'd0) begin
      bad++;
      $display("FAIL rounds_after got last=%b cyc=%0d want 0 0", last_round, cycle_num);
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL rounds_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_stray();
    logic [24:0] saved;
    saved = m_mem[7];
    drive(1, 0, 1, 25'($urandom), 6'd7);
    drive(1, 0, 0, '0, 6'd7);
    total++;
    if (overrun !== 1'b1 || rd_data !== saved || ready !== 1'b1) begin
      bad++;
      $display("FAIL stray_done got ovr=%b rd=%h rdy=%b want 1 %h 1", overrun, rd_data, ready,
               saved);
    end
    drive(0, 0, 0, '0, 6'd9);
    saved = m_mem[9];
    drive(1, 0, 1, 25'($urandom), 6'd9);
    drive(1, 0, 0, '0, 6'd9);
    total++;
    if (overrun !== 1'b1 || rd_data !== saved || busy !== 1'b0) begin
      bad++;
      $display("FAIL stray_idle got ovr=%b rd=%h busy=%b want 1 %h 0", overrun, rd_data, busy,
               saved);
    end
    drive(1, 1, 0, '0, raddr());
    total++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stray_clear got ovr=%b busy=%b want 0 1", overrun, busy);
    end
    for (int i = 0; i < NS; i++) drive(1, 0, 1, 25'($urandom), raddr());
    total++;
    if ({busy, ready, cycle_num, last_round, overrun} !== exp_status()) begin
      bad++;
      $display("FAIL stray_frame got %b want %b", {busy, ready, cycle_num, last_round, overrun},
               exp_status());
    end
  endtask

  task automatic test_start_mid();
    logic [24:0] first;
    drive(1, 1, 0, '0, raddr());
    for (int i = 0; i < 30; i++) drive(1, 0, 1, 25'($urandom), raddr());
    drive(1, 1, 0, '0, raddr());
    drive(1, 1, 1, 25'($urandom), raddr());
    for (int i = 31; i < NS - 1; i++) drive(1, 0, 1, 25'($urandom), raddr());
    total++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_before got ready=%b busy=%b want 0 1", ready, busy);
    end
    drive(1, 0, 1, 25'($urandom), raddr());
    total++;
    if ({busy, ready, cycle_num, last_round, overrun} !== exp_status() || ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_done got %b want %b", {busy, ready, cycle_num, last_round, overrun},
               exp_status());
    end
    for (int a = 0; a < NS; a++) begin
      drive(1, 0, 0, '0, 6'(a));
      total++;
      if (rd_data !== m_mem[a]) begin
        bad++;
        $display("FAIL mid_read addr %0d got %h want %h", a, rd_data, m_mem[a]);
      end
    end
    // start together with a slice in IDLE: slice dropped, first stored slice follows.
    drive(0, 0, 0, '0, raddr());
    drive(1, 1, 1, 25'h1ABCDE, raddr());
    total++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL drop_start got ovr=%b busy=%b want 0 1", overrun, busy);
    end
    first = 25'($urandom) ^ 25'h0000001;
    if (first == 25'h1ABCDE) first = 25'h0123456;
    drive(1, 0, 1, first, raddr());
    for (int i = 1; i < NS - 1; i++) drive(1, 0, 1, 25'($urandom), raddr());
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL drop_count got ready=%b want 0 after 63 slices", ready);
    end
    drive(1, 0, 1, 25'($urandom), 6'd0);
    drive(1, 0, 0, '0, 6'd0);
    total++;
    if (ready !== 1'b1 || rd_data !== first) begin
      bad++;
      $display("FAIL drop_first got ready=%b rd=%h want 1 %h", ready, rd_data, first);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, '0, raddr());
    for (int f = 0; f < 5; f++) run_frame();
    total++;
    if (cycle_num !== 5'd5) begin
      bad++;
      $display("FAIL rmid_round got %0d want 5", cycle_num);
    end
    drive(1, 1, 0, '0, raddr());
    for (int i = 0; i < 40; i++) drive(1, 0, 1, 25'($urandom), raddr());
    drive(0, 0, 1, 25'($urandom), raddr());
    total++;
    if (busy !== 1'b0 || ready !== 1'b0 || cycle_num !== 5'd0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL rmid_reset got busy=%b ready=%b cyc=%0d ovr=%b want 0 0 0 0", busy, ready,
               cycle_num, overrun);
    end
    run_frame();
    total++;
    if (ready !== 1'b1 || cycle_num !== 5'd1) begin
      bad++;
      $display("FAIL rmid_frame got ready=%b cyc=%0d want 1 1", ready, cycle_num);
    end
    for (int a = 0; a < NS; a++) begin
      drive(1, 0, 0, '0, 6'(a));
      total++;
      if (rd_data !== m_mem[a]) begin
        bad++;
        $display("FAIL rmid_read addr %0d got %h want %h", a, rd_data, m_mem[a]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < NS; i++) m_known[i] = 0;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; din = '0; rd_addr = '0;
    m_phase = MIdle; m_cnt = 0; m_round = 0; m_last = 0; m_ovr = 0;
    m_rd = '0; m_rd_known = 0;
    #2;
    test_reset();
    test_full_round();
    test_gapped();
    test_rounds();
    test_stray();
    test_start_mid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slice_collector.md
# slice_collector

Receiving end of the 25-bit Keccak slice stream. It captures the 64 slices that the round-constant stage emits one per cycle into a 64×25 state buffer. When the frame is complete it signals completion and advances the 5-bit round number that feeds the next round. Stored slices are available through a registered random-access read port for the next permutation stage.

## Interface
Parameters:
- SLICES, 64: slices per frame (lane width); index width is 6.
- ROUNDS, 24: rounds per permutation; cycleNum counts 0..ROUNDS-1.
- WIDTH, 25: bits per slice (5×5 plane).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  begin collecting a new frame.
- in  input  25  slice data from upstream.
- inValid  input  1  `in` holds a valid slice this cycle; upstream's putInput-style strobe.
- rdAddr  input  6  slice index to read.
- rdData  output  25  registered read data, mem[rdAddr].
- ready  output  1  frame complete; all 64 slices stored.
- busy  output  1  collecting.
- cycleNum  output  5  current round number, fed to the upstream stage.
- lastRound  output  1  one-cycle pulse when cycleNum wraps from ROUNDS-1 to 0.
- overrun  output  1  sticky error flag: a slice arrived while not collecting.

## Operation
- States:
  - IDLE: after reset.
  - COLLECT: busy=1.
  - DONE: ready=1.
- IDLE/DONE + start → COLLECT. Slice counter cleared to 0, ready cleared, overrun cleared.
- COLLECT + inValid:
  - Write mem[count] ← in; count++.
  - If count==SLICES-1 when the write happens, go to DONE and count wraps to 0.
- COLLECT + !inValid: hold. There is no timeout; gaps between slices are allowed.
- Entering DONE: cycleNum ← cycleNum+1. If cycleNum was ROUNDS-1, cycleNum ← 0 and lastRound pulses for exactly one cycle.
- DONE holds until the next start. The buffer contents stay stable.
- start while in COLLECT: ignored. Collection continues and count is unchanged.
- start and inValid in the same cycle in IDLE/DONE: start wins and the slice is discarded. overrun is not set.
- inValid in IDLE or DONE without start: no write. overrun ← 1.
- Read port: rdData ← mem[rdAddr] every cycle, in any state.
  - Simultaneous write and read of the same address returns the old value (read-before-write).
- Reset values:
  - state=IDLE, count=0, cycleNum=0.
  - ready=0, busy=0, lastRound=0, overrun=0, rdData=0.
  - Buffer memory is not cleared; contents are undefined until written.
- Reset asserted mid-COLLECT: everything above returns to its reset value on the next edge, including cycleNum. Partial frame data is abandoned.

## Timing
- start sampled at edge N → busy=1 after edge N. The first slice can be accepted at edge N+1.
- A back-to-back stream of 64 slices at edges N+1..N+64 gives:
  - ready=1, busy=0 and the new cycleNum, all visible after edge N+64.
  - lastRound, if applicable, also visible after edge N+64 and low after N+65.
- Minimum frame time is 65 cycles from start to ready.
- Read latency is 1 cycle: rdAddr presented before edge K → rdData valid after edge K.
- ready, busy, cycleNum, lastRound and overrun are all registered. No combinational path from inputs to outputs.

## Test plan
- Reset, then full round: start, 64 consecutive slices with in=index×0x10001 → ready=1 after the 64th edge, cycleNum=1; reading rdAddr 0..63 returns index×0x10001 with 1-cycle latency.
- Gapped stream: inValid toggled 1/0 for 64 slices → ready only after the 64th valid slice (128 cycles); stored data matches and contains no duplicates.
- 24 successive frames → cycleNum steps 0→23. On the 24th frame, cycleNum returns to 0 and lastRound is high for exactly one cycle.
- Stray inValid in DONE and in IDLE → no memory change (rdData unchanged), overrun=1; the next start clears overrun.
- start reasserted at slice 30 → ignored; ready after slice 64. start together with inValid in IDLE → slice dropped, count stays 0.
- rst low at slice 40 of round 5 → next cycle: busy=0, ready=0, cycleNum=0. A new full frame then completes normally with cycleNum=1.
